// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter for the picorv32 native bus.
//
// CPU stores to DATA push bytes into a TX FIFO; a bit-timing FSM drains the
// FIFO onto tx with a programmable bit period of (div+1) clocks.
//
// Register map (offset mem_addr[3:2]):
//   0 DATA   : write wstrb[0] pushes wdata[7:0]; reads 0
//   1 STATUS : {count[15:8], ovf[3], busy[2], full[1], empty[0]};
//              write wstrb[0] with wdata[3]=1 clears ovf
//   2 DIV    : 16-bit baud divisor, byte-writable via wstrb[1:0]
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   mem_valid    : bus request valid
//   mem_addr     : byte address
//   mem_wdata    : write data
//   mem_wstrb    : byte strobes, 0 = read
//   uart_sel     : combinational address decode (16-byte window at ADDR)
//   uart_ready   : registered one-cycle transaction completion
//   uart_rdata   : read data, 0 whenever uart_ready is low
//   tx           : registered serial output, idle high
module uart_tx_periph #(
  parameter logic [31:0] ADDR        = 32'h4000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        uart_sel,
  output logic        uart_ready,
  output logic [31:0] uart_rdata,
  output logic        tx
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic       accept;
  logic       is_wr;
  logic [1:0] reg_off;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic       ovf_clr;
  logic [31:0] rd_val;

  // Registers
  logic        ovf;
  logic [15:0] div;

  // FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          full;
  logic [7:0]    count8;

  // Transmit FSM
  state_t      state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [15:0] baud_cnt;
  logic [15:0] bit_reload;
  logic        busy;

  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign uart_sel = mem_valid && (mem_addr[31:4] == ADDR[31:4]);
  // A request is taken only in the cycle after a completion has dropped,
  // giving the fixed two-cycle request/complete handshake.
  assign accept   = uart_sel && !uart_ready;
  assign is_wr    = |mem_wstrb;
  assign reg_off  = mem_addr[3:2];

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign count8 = 8'(count);
  assign busy   = (state != S_IDLE);

  // full is the pre-pop value, so a push into a full FIFO is dropped even
  // if the FSM frees a slot on the same edge.
  assign push    = accept && is_wr && (reg_off == 2'd0) && mem_wstrb[0] && !full;
  assign ovf_set = accept && is_wr && (reg_off == 2'd0) && mem_wstrb[0] && full;
  assign ovf_clr = accept && is_wr && (reg_off == 2'd1) && mem_wstrb[0] && mem_wdata[3];
  assign pop     = (state == S_IDLE) && !empty;

  always_comb begin
    rd_val = '0;
    unique case (reg_off)
      2'd1:    rd_val = {16'h0, count8, 4'h0, ovf, busy, full, empty};
      2'd2:    rd_val = {16'h0, div};
      default: rd_val = '0;
    endcase
  end

  // Bus response and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_ready <= 1'b0;
      uart_rdata <= '0;
      ovf        <= 1'b0;
      div        <= DEFAULT_DIV;
    end else begin
      uart_ready <= accept;
      uart_rdata <= (accept && !is_wr) ? rd_val : '0;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (accept && is_wr && (reg_off == 2'd2)) begin
        if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
      end
    end
  end

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM. tx is registered from the current state, so each level
  // appears one clock after the state that produces it; this yields the
  // two-clock push-to-start latency and the single idle clock between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      baud_cnt   <= '0;
      bit_reload <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg      <= fifo_mem[rd_ptr];
            bit_reload <= div;
            baud_cnt   <= div;
            bit_idx    <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (baud_cnt == '0) begin
            baud_cnt <= bit_reload;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          tx <= shreg[0];
          if (baud_cnt == '0) begin
            baud_cnt <= bit_reload;
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: register vector table, a serial
// frame monitor fed by an expected-byte queue, and hand-written sequences
// for latency, overflow, back-to-back frames and mid-frame reset.
module tb_uart_tx_periph;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        uart_sel;
  logic        uart_ready;
  logic [31:0] uart_rdata;
  logic        tx;

  uart_tx_periph #(
    .ADDR        (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd103)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .uart_sel   (uart_sel),
    .uart_ready (uart_ready),
    .uart_rdata (uart_rdata),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state shared with the frame monitor
  logic [7:0]  exp_q[$];
  int unsigned mon_div = 103;
  int unsigned frames_started = 0;
  int unsigned frames_done = 0;
  int unsigned start_cyc [64];

  typedef struct {
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd,
                         input bit chk, input logic [31:0] exp, input string name);
    vec_t v;
    v.off = off; v.strb = strb; v.wdata = wd; v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic bus(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = BASE | {28'h0, off, 2'b00};
    mem_wdata = wd;
    mem_wstrb = strb;
    @(posedge clk); #1;
    check("bus_ready", {31'h0, uart_ready}, 32'h1);
    rd = uart_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic reg_rd(input logic [1:0] off, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus(off, 4'h0, 32'h0, d);
    check(name, d, exp);
  endtask

  task automatic reg_wr(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] d;
    bus(off, strb, wd, d);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    reg_wr(2'd0, 4'h1, {24'h0, b});
  endtask

  task automatic wait_frames(input int unsigned n, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frames_done", 32'(frames_done), 32'(n));
  endtask

  // Serial frame monitor: checks every clock of each frame against the
  // expected byte at the bit period in force when the frame started.
  initial begin : monitor
    int unsigned p, slot;
    logic [7:0]  exp_b, got;
    logic        e;
    bit          bad, abort, have;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        p = mon_div + 1;
        start_cyc[frames_started % 64] = cyc;
        frames_started++;
        have  = (exp_q.size() > 0);
        exp_b = have ? exp_q.pop_front() : 8'h00;
        bad = 0; abort = 0; got = '0;
        for (int unsigned k = 1; k < 10 * p; k++) begin
          @(negedge clk);
          if (reset) begin
            abort = 1;
            break;
          end
          slot = k / p;
          if (slot == 0)      e = 1'b0;
          else if (slot == 9) e = 1'b1;
          else                e = exp_b[slot-1];
          if (slot >= 1 && slot <= 8 && (k % p) == p / 2) got[slot-1] = tx;
          if (tx !== e) bad = 1;
        end
        if (!abort) begin
          n_vec++;
          if (!have || bad || got !== exp_b) begin
            n_bad++;
            $display("FAIL frame: got %02h timing_ok=%0d, expected %02h queued=%0d",
                     got, !bad, exp_b, have);
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int unsigned s0, done0, st0;

    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_ready", {31'h0, uart_ready}, 32'h0);
    check("rst_rdata", uart_rdata, 32'h0);

    // Address decode and handshake timing
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h4000_2004; mem_wstrb = 4'h0;
    #1 check("sel_miss", {31'h0, uart_sel}, 32'h0);
    @(posedge clk); #1 check("ready_miss", {31'h0, uart_ready}, 32'h0);
    mem_valid = 1'b0; mem_addr = BASE + 32'h4;
    #1 check("sel_novalid", {31'h0, uart_sel}, 32'h0);
    mem_valid = 1'b1;
    #1 check("sel_hit", {31'h0, uart_sel}, 32'h1);
    @(posedge clk); #1;
    check("hs_ready_n1", {31'h0, uart_ready}, 32'h1);
    check("hs_rdata_n1", uart_rdata, 32'h1);
    @(posedge clk); #1;
    check("hs_ready_n2", {31'h0, uart_ready}, 32'h0);
    check("hs_rdata_n2", uart_rdata, 32'h0);
    @(posedge clk); #1;
    check("hs_ready_n3", {31'h0, uart_ready}, 32'h1);
    mem_valid = 1'b0;
    @(posedge clk); #1 check("hs_ready_idle", {31'h0, uart_ready}, 32'h0);

    // Register vector table
    add_vec(2'd1, 4'h0, 32'h0,         1, 32'h0000_0001, "status_rst");
    add_vec(2'd2, 4'h0, 32'h0,         1, 32'h0000_0067, "div_rst");
    add_vec(2'd0, 4'h0, 32'h0,         1, 32'h0000_0000, "data_rd");
    add_vec(2'd3, 4'h0, 32'h0,         1, 32'h0000_0000, "rsvd_rd");
    add_vec(2'd3, 4'hF, 32'hFFFF_FFFF, 0, 32'h0,         "rsvd_wr");
    add_vec(2'd3, 4'h0, 32'h0,         1, 32'h0000_0000, "rsvd_rd2");
    add_vec(2'd2, 4'h2, 32'h0000_1200, 0, 32'h0,         "div_wr_b1");
    add_vec(2'd2, 4'h0, 32'h0,         1, 32'h0000_1267, "div_b1");
    add_vec(2'd2, 4'h1, 32'h0000_0034, 0, 32'h0,         "div_wr_b0");
    add_vec(2'd2, 4'h0, 32'h0,         1, 32'h0000_1234, "div_b0");
    add_vec(2'd2, 4'hC, 32'hFFFF_0000, 0, 32'h0,         "div_wr_hi");
    add_vec(2'd2, 4'h0, 32'h0,         1, 32'h0000_1234, "div_hi_ign");
    add_vec(2'd1, 4'h1, 32'h0000_0008, 0, 32'h0,         "ovf_clr_idle");
    add_vec(2'd1, 4'h0, 32'h0,         1, 32'h0000_0001, "status_clr");
    add_vec(2'd2, 4'h3, 32'h0000_0003, 0, 32'h0,         "div_wr_3");
    add_vec(2'd2, 4'h0, 32'h0,         1, 32'h0000_0003, "div_3");
    foreach (vecs[i]) begin
      bus(vecs[i].off, vecs[i].strb, vecs[i].wdata, d);
      if (vecs[i].chk) check(vecs[i].name, d, vecs[i].exp);
    end
    mon_div = 3;

    // Single frame 0xA5 at div=3: latency, busy/empty during frame
    done0 = frames_done;
    push_byte(8'hA5, 1);
    check("lat_push_edge", {31'h0, tx}, 32'h1);
    @(posedge clk); #1 check("lat_pop_edge", {31'h0, tx}, 32'h1);
    @(posedge clk); #1 check("lat_start", {31'h0, tx}, 32'h0);
    reg_rd(2'd1, 32'h0000_0005, "status_busy");
    wait_frames(done0 + 1, 200);
    reg_rd(2'd1, 32'h0000_0001, "status_after_a5");

    // Overflow while a slow frame is in flight, then drain at div=0
    reg_wr(2'd2, 4'h3, 32'd40);
    mon_div = 40;
    s0 = frames_started;
    done0 = frames_done;
    push_byte(8'h5A, 1);
    repeat (2) @(posedge clk);
    for (int unsigned i = 0; i < 8; i++) push_byte(8'(i), 1);
    push_byte(8'hFF, 0);
    reg_rd(2'd1, 32'h0000_080E, "status_full_ovf");
    reg_wr(2'd1, 4'h1, 32'h0000_0008);
    reg_rd(2'd1, 32'h0000_0806, "status_ovf_clr");
    push_byte(8'hFF, 0);
    reg_rd(2'd1, 32'h0000_080E, "status_ovf_again");
    reg_wr(2'd2, 4'h3, 32'h0000_0000);
    reg_rd(2'd2, 32'h0000_0000, "div_0");
    mon_div = 0;
    wait_frames(done0 + 9, 3000);
    for (int unsigned k = 1; k < 8; k++)
      check("b2b_gap", start_cyc[(s0 + 1 + k) % 64] - start_cyc[(s0 + k) % 64], 32'd11);
    reg_rd(2'd1, 32'h0000_0009, "status_drained");
    reg_wr(2'd1, 4'h1, 32'h0000_0008);
    reg_rd(2'd1, 32'h0000_0001, "status_final_clr");

    // Reset mid-DATA with bytes still queued
    reg_wr(2'd2, 4'h3, 32'd3);
    mon_div = 3;
    push_byte(8'h11, 1);
    push_byte(8'h22, 1);
    push_byte(8'h33, 1);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx", {31'h0, tx}, 32'h1);
    reset = 1'b0;
    exp_q.delete();
    st0 = frames_started;
    repeat (100) @(posedge clk);
    #1 check("rst_no_frames", 32'(frames_started), 32'(st0));
    reg_rd(2'd1, 32'h0000_0001, "rst_mid_status");
    reg_rd(2'd2, 32'h0000_0067, "rst_mid_div");
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
